// File: rtl/cordic_pipe_if.sv
// cordic_pipe_if: valid/ready sample bus for the pipelined CORDIC engine.
//   in_*  : sample side (valid, ready, mode, x, y, angle, tag)
//   out_* : result side (valid, ready, x, y, angle, mode, tag)
//   master : sample producer / result consumer view
//   slave  : CORDIC core view
interface cordic_pipe_if #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int unsigned TAG_WIDTH = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_mode;
  logic signed [BIT_WIDTH-1:0] in_x;
  logic signed [BIT_WIDTH-1:0] in_y;
  logic signed [BIT_WIDTH-1:0] in_angle;
  logic [TAG_WIDTH-1:0]        in_tag;

  logic                        out_valid;
  logic                        out_ready;
  logic signed [BIT_WIDTH-1:0] out_x;
  logic signed [BIT_WIDTH-1:0] out_y;
  logic signed [BIT_WIDTH-1:0] out_angle;
  logic                        out_mode;
  logic [TAG_WIDTH-1:0]        out_tag;

  modport master (
    output in_valid, in_mode, in_x, in_y, in_angle, in_tag, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_angle, out_mode, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in_x, in_y, in_angle, in_tag, out_ready,
    output in_ready, out_valid, out_x, out_y, out_angle, out_mode, out_tag
  );
endinterface

// File: rtl/cordic_pipe.sv
// cordic_pipe: fully pipelined CORDIC, one iteration per stage, one sample per clock.
// Each sample selects rotation (rotate (x,y) by in_angle) or vectoring (drive y to 0 and
// report the accumulated angle). Angle unit: pi = 2**(BIT_WIDTH-1) LSB. No gain correction.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; drops every in-flight sample
//   bus   : cordic_pipe_if.slave (in_* sample side, out_* result side, valid/ready each)
// A stalled output (out_valid & ~out_ready) freezes the whole pipe; in_ready = ~stall.
module cordic_pipe #(
  parameter int unsigned BIT_WIDTH       = 16,
  parameter int unsigned STAGES          = 16,
  parameter int unsigned LOG_2_BIT_WIDTH = 4,
  parameter int unsigned TAG_WIDTH       = 4
) (
  input  logic         clk,
  input  logic         reset,
  cordic_pipe_if.slave bus
);

  localparam int unsigned GW = BIT_WIDTH + 2;  // x/y with two guard bits for the K*sqrt(2) growth
  localparam int unsigned ZW = BIT_WIDTH + 1;  // angle accumulator
  // The arctangent table is held at 16-bit angle resolution and rescaled to BIT_WIDTH.
  localparam int LutShl = (int'(BIT_WIDTH) > 16) ? int'(BIT_WIDTH) - 16 : 0;
  localparam int LutShr = (int'(BIT_WIDTH) < 16) ? 16 - int'(BIT_WIDTH) : 0;

  // round(atan(2^-i) * 2**(BIT_WIDTH-1) / pi)
  function automatic logic signed [ZW-1:0] cordic_lut(input logic [LOG_2_BIT_WIDTH-1:0] idx);
    int base;
    int v;
    case (int'(idx))
      0:       base = 8192;
      1:       base = 4836;
      2:       base = 2555;
      3:       base = 1297;
      4:       base = 651;
      5:       base = 326;
      6:       base = 163;
      7:       base = 81;
      8:       base = 41;
      9:       base = 20;
      10:      base = 10;
      11:      base = 5;
      12:      base = 3;
      13:      base = 1;
      14:      base = 1;
      default: base = 0;
    endcase
    v = base <<< LutShl;
    v = (v + ((1 <<< LutShr) >>> 1)) >>> LutShr;
    return v[ZW-1:0];
  endfunction

  function automatic logic signed [BIT_WIDTH-1:0] sat_xy(input logic signed [GW-1:0] v);
    logic signed [GW-1:0] hi;
    logic signed [GW-1:0] lo;
    hi = {3'b000, {(BIT_WIDTH-1){1'b1}}};
    lo = {3'b111, {(BIT_WIDTH-1){1'b0}}};
    if (v > hi)      return hi[BIT_WIDTH-1:0];
    else if (v < lo) return lo[BIT_WIDTH-1:0];
    else             return v[BIT_WIDTH-1:0];
  endfunction

  function automatic logic signed [BIT_WIDTH-1:0] sat_z(input logic signed [ZW-1:0] v);
    logic signed [ZW-1:0] hi;
    logic signed [ZW-1:0] lo;
    hi = {2'b00, {(BIT_WIDTH-1){1'b1}}};
    lo = {2'b11, {(BIT_WIDTH-1){1'b0}}};
    if (v > hi)      return hi[BIT_WIDTH-1:0];
    else if (v < lo) return lo[BIT_WIDTH-1:0];
    else             return v[BIT_WIDTH-1:0];
  endfunction

  // r_*[i] holds the sample after iteration i.
  logic signed [GW-1:0]        r_x    [STAGES];
  logic signed [GW-1:0]        r_y    [STAGES];
  logic signed [ZW-1:0]        r_z    [STAGES];
  logic signed [BIT_WIDTH-1:0] r_t    [STAGES];
  logic                        r_mode [STAGES];
  logic [TAG_WIDTH-1:0]        r_tag  [STAGES];
  logic [STAGES-1:0]           r_valid;

  // w_src_*[i] is the operand of iteration i: the inputs for i = 0, stage i-1 otherwise.
  logic signed [GW-1:0]        w_src_x [STAGES];
  logic signed [GW-1:0]        w_src_y [STAGES];
  logic signed [ZW-1:0]        w_src_z [STAGES];
  logic signed [BIT_WIDTH-1:0] w_src_t [STAGES];
  logic                        w_src_m [STAGES];
  logic [TAG_WIDTH-1:0]        w_src_g [STAGES];
  logic signed [GW-1:0]        w_xs    [STAGES];
  logic signed [GW-1:0]        w_ys    [STAGES];
  logic signed [ZW-1:0]        w_lut   [STAGES];
  logic                        w_dir   [STAGES];
  logic signed [GW-1:0]        w_nx    [STAGES];
  logic signed [GW-1:0]        w_ny    [STAGES];
  logic signed [ZW-1:0]        w_nz    [STAGES];
  logic                        w_stall;

  assign w_stall      = r_valid[STAGES-1] & ~bus.out_ready;
  assign bus.in_ready = ~w_stall;

  always_comb begin
    w_src_x[0] = {{2{bus.in_x[BIT_WIDTH-1]}}, bus.in_x};
    w_src_y[0] = {{2{bus.in_y[BIT_WIDTH-1]}}, bus.in_y};
    w_src_z[0] = '0;
    w_src_t[0] = bus.in_angle;
    w_src_m[0] = bus.in_mode;
    w_src_g[0] = bus.in_tag;
    for (int i = 1; i < STAGES; i++) begin
      w_src_x[i] = r_x[i-1];
      w_src_y[i] = r_y[i-1];
      w_src_z[i] = r_z[i-1];
      w_src_t[i] = r_t[i-1];
      w_src_m[i] = r_mode[i-1];
      w_src_g[i] = r_tag[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      w_lut[i] = cordic_lut(LOG_2_BIT_WIDTH'(i));
      // Rotation chases the target angle; vectoring chases y = 0.
      w_dir[i] = w_src_m[i] ? w_src_y[i][GW-1]
                            : (w_src_z[i] < $signed({w_src_t[i][BIT_WIDTH-1], w_src_t[i]}));
      w_xs[i]  = w_src_x[i] >>> i;
      w_ys[i]  = w_src_y[i] >>> i;
      if (w_dir[i]) begin
        w_nx[i] = w_src_x[i] - w_ys[i];
        w_ny[i] = w_src_y[i] + w_xs[i];
        w_nz[i] = w_src_m[i] ? (w_src_z[i] - w_lut[i]) : (w_src_z[i] + w_lut[i]);
      end else begin
        w_nx[i] = w_src_x[i] + w_ys[i];
        w_ny[i] = w_src_y[i] - w_xs[i];
        w_nz[i] = w_src_m[i] ? (w_src_z[i] + w_lut[i]) : (w_src_z[i] - w_lut[i]);
      end
    end
  end

  // Data shifts on every unstalled cycle; empty slots simply carry valid = 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_x[i]    <= '0;
        r_y[i]    <= '0;
        r_z[i]    <= '0;
        r_t[i]    <= '0;
        r_mode[i] <= 1'b0;
        r_tag[i]  <= '0;
      end
    end else if (!w_stall) begin
      r_valid[0] <= bus.in_valid;
      for (int i = 1; i < STAGES; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
      for (int i = 0; i < STAGES; i++) begin
        r_x[i]    <= w_nx[i];
        r_y[i]    <= w_ny[i];
        r_z[i]    <= w_nz[i];
        r_t[i]    <= w_src_t[i];
        r_mode[i] <= w_src_m[i];
        r_tag[i]  <= w_src_g[i];
      end
    end
  end

  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.out_x     = sat_xy(r_x[STAGES-1]);
  assign bus.out_y     = sat_xy(r_y[STAGES-1]);
  assign bus.out_angle = sat_z(r_z[STAGES-1]);
  assign bus.out_mode  = r_mode[STAGES-1];
  assign bus.out_tag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_cordic_pipe.sv
module tb_cordic_pipe;
  localparam int W  = 16;
  localparam int S  = 16;
  localparam int TW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  cordic_pipe_if #(.BIT_WIDTH(W), .TAG_WIDTH(TW)) bus ();

  cordic_pipe #(
    .BIT_WIDTH      (W),
    .STAGES         (S),
    .LOG_2_BIT_WIDTH(4),
    .TAG_WIDTH      (TW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  bit bp_en    = 1'b0;

  // Directed vectors; tolerance -1 means the field is not checked.
  int v_mode [4] = '{0, 1, 1, 0};
  int v_x    [4] = '{10000, 10000, 32767, -32768};
  int v_y    [4] = '{0, 10000, 32767, 0};
  int v_a    [4] = '{8192, -7000, 5000, 0};
  int e_x    [4] = '{11645, 23290, 32767, -32768};
  int t_x    [4] = '{4, 6, 0, 0};
  int e_y    [4] = '{11645, 0, 0, 0};
  int t_y    [4] = '{4, 4, -1, -1};
  int e_a    [4] = '{8192, 8192, 8192, 0};
  int t_a    [4] = '{2, 2, 2, -1};

  typedef struct {
    bit mode;
    int tag;
    int ex, ey, ea;
    int tx, ty, ta;
    int cyc;
    bit lat;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp, input int tol);
    if (tol < 0) return;
    checks++;
    if ((act - exp) > tol || (exp - act) > tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  always @(negedge clk) bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;

  // Monitor: samples one time unit after the falling edge, when this cycle's handshake
  // signals are settled; a transfer seen here completes on the next rising edge.
  initial begin : monitor
    exp_t e;
    logic prev_stall;
    logic [3*W+TW+1:0] prev_out;
    logic [3*W+TW+1:0] cur_out;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      #1;
      cur_out = {bus.out_valid, bus.out_mode, bus.out_tag, bus.out_x, bus.out_y, bus.out_angle};
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        chk("in_ready", int'(bus.in_ready), int'(!(bus.out_valid && !bus.out_ready)), 0);
        if (prev_stall) begin
          checks++;
          if (cur_out !== prev_out) begin
            failures++;
            $display("FAIL hold: got %h expected %h at cycle %0d", cur_out, prev_out, cyc);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected: got output tag %0d expected none at cycle %0d",
                     bus.out_tag, cyc);
          end else begin
            e = sb.pop_front();
            chk("tag", int'(bus.out_tag), e.tag, 0);
            chk("mode", int'(bus.out_mode), int'(e.mode), 0);
            chk("out_x", int'(bus.out_x), e.ex, e.tx);
            chk("out_y", int'(bus.out_y), e.ey, e.ty);
            chk("out_angle", int'(bus.out_angle), e.ea, e.ta);
            if (e.lat) chk("latency", cyc - e.cyc, S, 0);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
      end
      prev_out = cur_out;
    end
  end

  // Called at a falling edge; returns at a later falling edge after the transfer.
  task automatic send(input int v, input int tag, input bit lat);
    exp_t e;
    int   guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = 1'(v_mode[v]);
    bus.in_x     = W'(v_x[v]);
    bus.in_y     = W'(v_y[v]);
    bus.in_angle = W'(v_a[v]);
    bus.in_tag   = TW'(tag);
    #1;
    while (!bus.in_ready) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > 1000) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got in_ready 0 expected 1 within 1000 cycles");
        bus.in_valid = 1'b0;
        return;
      end
    end
    e.mode = v_mode[v][0];
    e.tag  = tag % 16;
    e.ex   = e_x[v];
    e.ey   = e_y[v];
    e.ea   = e_a[v];
    e.tx   = t_x[v];
    e.ty   = t_y[v];
    e.ta   = t_a[v];
    e.cyc  = cyc;
    e.lat  = lat;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin : driver
    bus.in_valid = 1'b0;
    bus.in_mode  = 1'b0;
    bus.in_x     = '0;
    bus.in_y     = '0;
    bus.in_angle = '0;
    bus.in_tag   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0, 0);
    chk("rst_in_ready", int'(bus.in_ready), 1, 0);
    chk("rst_out_x", int'(bus.out_x), 0, 0);
    chk("rst_out_y", int'(bus.out_y), 0, 0);
    chk("rst_out_angle", int'(bus.out_angle), 0, 0);
    chk("rst_out_mode", int'(bus.out_mode), 0, 0);
    chk("rst_out_tag", int'(bus.out_tag), 0, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Isolated directed samples
    for (int v = 0; v < 4; v++) begin
      send(v, v + 1, 1'b1);
      wait_drain(S + 8);
    end

    // Back-to-back mixed-mode stream; a fixed latency on every sample means 1/clk
    for (int k = 0; k < 100; k++) send(k % 4, k % 16, 1'b1);
    wait_drain(S + 8);

    // Random backpressure
    bp_en = 1'b1;
    for (int k = 0; k < 60; k++) send((k * 3) % 4, k % 16, 1'b0);
    wait_drain(600);
    bp_en = 1'b0;
    idle(2);

    // Reset with 8 samples in flight
    for (int k = 0; k < 8; k++) send(k % 4, k, 1'b0);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    sb.delete();
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0, 0);
    chk("midrst_out_x", int'(bus.out_x), 0, 0);
    chk("midrst_out_y", int'(bus.out_y), 0, 0);
    chk("midrst_out_angle", int'(bus.out_angle), 0, 0);
    chk("midrst_out_tag", int'(bus.out_tag), 0, 0);
    @(negedge clk);
    #1;
    chk("midrst_hold_valid", int'(bus.out_valid), 0, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(S + 20);

    // Pipe still works after the flush
    send(0, 9, 1'b1);
    wait_drain(S + 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
